snn_pool_scheduler: RTL and testbench

SNN_POOL_SCHEDULER -- requirements
Module: snn_pool_scheduler

---
 rtl/snn_pkg.sv | 25 ++
 rtl/snn_rr_arbiter.sv | 37 +++
 rtl/snn_pool_scheduler.sv | 174 +++++++++++++++++
 tb/tb_snn_pool_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types for the SNN pooling scheduler: FSM states, stream width and beat layout.
package snn_pkg;

  localparam int AXIS_DW = 32;
  localparam int GRANT_W = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONFIG    = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic               last;
    logic [AXIS_DW-1:0] data;
  } axis_beat_t;

  // Index of the requester after idx, wrapping at n.
  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// Round-robin selector: first asserted request at or after ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency; no backpressure of its own.
module snn_rr_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] gnt_idx,
  output logic               gnt_vld
);

  localparam int CW = GRANT_W + 1;

  logic [MAX_REQ-1:0] req_ext;
  logic [CW-1:0]      cand;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    gnt_idx              = '0;
    gnt_vld              = 1'b0;
    cand                 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!gnt_vld && req_ext[cand[GRANT_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[GRANT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/snn_pool_scheduler.sv
// Grants one spike stream at a time to the pooling engine: config word, stream frame, wait for done.
// Stream path is zero-latency; pool_tready is routed straight back to the granted requester only.
module snn_pool_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_tvalid,
  input  logic [NUM_REQ*AXIS_DW-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]         req_tlast,
  output logic [NUM_REQ-1:0]         req_tready,
  input  logic [NUM_REQ*AXIS_DW-1:0] req_cfg,
  output logic                       pool_config_valid,
  output logic [AXIS_DW-1:0]         pool_config_data,
  output logic                       pool_tvalid,
  output logic [AXIS_DW-1:0]         pool_tdata,
  output logic                       pool_tlast,
  input  logic                       pool_tready,
  input  logic                       pool_busy,
  input  logic                       pool_layer_done,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       sched_busy,
  output logic                       frame_done,
  output logic                       timeout_err,
  output logic [CNT_WIDTH-1:0]       frame_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  sched_state_e         state_q, state_d;
  logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;

  logic [GRANT_W-1:0]   arb_idx;
  logic                 arb_vld;
  logic [GRANT_W-1:0]   next_rr;
  logic                 in_stream;
  logic                 beat_fire;
  logic [MAX_REQ-1:0]   vld_ext;
  logic [MAX_REQ-1:0]   rdy_ext;
  axis_beat_t           beat_arr [MAX_REQ];
  logic [AXIS_DW-1:0]   cfg_arr  [MAX_REQ];
  axis_beat_t           sel_beat;
  logic                 sel_vld;

  // The engine's busy flag carries no information the done handshake lacks.
  logic unused_pool_busy;
  assign unused_pool_busy = pool_busy;

  snn_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req    (req_tvalid),
    .ptr    (rr_ptr_q),
    .gnt_idx(arb_idx),
    .gnt_vld(arb_vld)
  );

  // Unpack the flat per-requester buses into fixed-size arrays indexable by grant_id.
  always_comb begin
    vld_ext = '0;
    for (int r = 0; r < MAX_REQ; r++) begin
      beat_arr[r] = '0;
      cfg_arr[r]  = '0;
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      vld_ext[r]       = req_tvalid[r];
      beat_arr[r].last = req_tlast[r];
      beat_arr[r].data = req_tdata[r*AXIS_DW +: AXIS_DW];
      cfg_arr[r]       = req_cfg[r*AXIS_DW +: AXIS_DW];
    end
  end

  assign sel_beat  = beat_arr[grant_id_q];
  assign sel_vld   = vld_ext[grant_id_q];
  assign in_stream = (state_q == ST_STREAM);
  assign next_rr   = wrap_inc(grant_id_q, NUM_REQ);

  always_comb begin
    pool_tvalid = in_stream & sel_vld;
    pool_tdata  = in_stream ? sel_beat.data : '0;
    pool_tlast  = in_stream & sel_beat.last;
    rdy_ext     = '0;
    if (in_stream) begin
      rdy_ext[grant_id_q] = pool_tready;
    end
    pool_config_valid = (state_q == ST_CONFIG);
    pool_config_data  = pool_config_valid ? cfg_arr[grant_id_q] : '0;
  end

  assign req_tready = rdy_ext[NUM_REQ-1:0];
  assign beat_fire  = pool_tvalid & pool_tready;

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    tmo_cnt_d     = tmo_cnt_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && arb_vld) begin
          grant_id_d = arb_idx;
          state_d    = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (beat_fire && pool_tlast) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (pool_layer_done) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
          rr_ptr_d      = next_rr;
          state_d       = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_rr;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      tmo_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      tmo_cnt_q     <= tmo_cnt_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grant_id    = grant_id_q;
  assign sched_busy  = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_snn_pool_scheduler.sv
// Directed bench for snn_pool_scheduler with a frame-level reference model and per-cycle compare.
module tb_snn_pool_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int CW   = 4;

  localparam int P_IDLE = 0, P_CONFIG = 1, P_STREAM = 2, P_WAIT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [NREQ-1:0]   req_tvalid = '0;
  logic [NREQ*32-1:0] req_tdata = '0;
  logic [NREQ-1:0]   req_tlast = '0;
  logic [NREQ-1:0]   req_tready;
  logic [NREQ*32-1:0] req_cfg;
  logic              pool_config_valid;
  logic [31:0]       pool_config_data;
  logic              pool_tvalid;
  logic [31:0]       pool_tdata;
  logic              pool_tlast;
  logic              pool_tready = 1'b1;
  logic              pool_busy = 1'b0;
  logic              pool_layer_done = 1'b0;
  logic [2:0]        grant_id;
  logic              sched_busy;
  logic              frame_done;
  logic              timeout_err;
  logic [CW-1:0]     frame_count;

  snn_pool_scheduler #(
    .NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tlast(req_tlast), .req_tready(req_tready),
    .req_cfg(req_cfg),
    .pool_config_valid(pool_config_valid), .pool_config_data(pool_config_data),
    .pool_tvalid(pool_tvalid), .pool_tdata(pool_tdata), .pool_tlast(pool_tlast), .pool_tready(pool_tready),
    .pool_busy(pool_busy), .pool_layer_done(pool_layer_done),
    .grant_id(grant_id), .sched_busy(sched_busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cfg_of(input int r);
    return 32'hC0F1_0000 + 32'(r);
  endfunction

  function automatic logic [31:0] beat_of(input int r, input int b);
    return 32'hD000_0000 | (32'(r) << 8) | 32'(b);
  endfunction

  // ---------------- reference model (frame-level rules) ----------------
  int m_phase = P_IDLE, m_grant = 0, m_rr = 0, m_wait = 0, m_fc = 0;
  bit m_fdone = 0, m_terr = 0;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE; m_grant <= 0; m_rr <= 0; m_wait <= 0;
      m_fc <= 0; m_fdone <= 0; m_terr <= 0;
    end else begin
      m_fdone <= 0;
      case (m_phase)
        P_IDLE: if (enable && (|req_tvalid)) begin
          m_grant <= rr_pick(req_tvalid, m_rr);
          m_phase <= P_CONFIG;
        end
        P_CONFIG: m_phase <= P_STREAM;
        P_STREAM: if (req_tvalid[m_grant] && pool_tready && req_tlast[m_grant]) begin
          m_phase <= P_WAIT;
          m_wait  <= 1;
        end
        default: begin
          if (pool_layer_done) begin
            m_fdone <= 1;
            m_fc    <= (m_fc + 1) % (1 << CW);
            m_rr    <= (m_grant + 1) % NREQ;
            m_phase <= P_IDLE;
          end else if (m_wait == TMO) begin
            m_terr  <= 1;
            m_rr    <= (m_grant + 1) % NREQ;
            m_phase <= P_IDLE;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("sched_busy", sched_busy, m_phase != P_IDLE);
    check("grant_id", grant_id, m_grant);
    check("cfg_valid", pool_config_valid, m_phase == P_CONFIG);
    if (m_phase == P_CONFIG) check("cfg_data", pool_config_data, cfg_of(m_grant));
    if (m_phase == P_STREAM) begin
      check("pool_tvalid", pool_tvalid, req_tvalid[m_grant]);
      check("pool_tdata", pool_tdata, req_tdata[32*m_grant +: 32]);
      check("pool_tlast", pool_tlast, req_tlast[m_grant]);
      check("req_tready", req_tready, pool_tready ? (4'b0001 << m_grant) : 4'b0000);
    end else begin
      check("pool_tvalid_idle", pool_tvalid, 0);
      check("req_tready_idle", req_tready, 0);
    end
    check("frame_done", frame_done, m_fdone);
    check("timeout_err", timeout_err, m_terr);
    check("frame_count", frame_count, m_fc);
    if (rst) begin
      check("rst_cfg_data", pool_config_data, 0);
      check("rst_tdata", pool_tdata, 0);
      check("rst_tlast", pool_tlast, 0);
    end
  end

  // ---------------- stimulus machinery ----------------
  bit src_on [NREQ];
  bit src_rep [NREQ];
  int src_len [NREQ];
  int src_beat [NREQ];
  bit tog = 0;
  int done_at = 2, wcnt = 0, cyc = 0, t_entry = -1, t_idle = -1, n_fdone = 0;
  bit busy_prev = 0;
  int glog[$];
  logic [31:0] cdlog[$];
  logic [32:0] blog[$];

  task automatic drive_src();
    for (int r = 0; r < NREQ; r++) begin
      req_tvalid[r]         = src_on[r];
      req_tdata[32*r +: 32] = beat_of(r, src_beat[r]);
      req_tlast[r]          = (src_beat[r] == src_len[r] - 1);
    end
  endtask

  task automatic set_src(input int r, input bit on, input bit rep, input int len);
    src_on[r] = on; src_rep[r] = rep; src_len[r] = len; src_beat[r] = 0;
    drive_src();
  endtask

  task automatic step();
    logic [NREQ-1:0] fire;
    bit last_fire;
    @(negedge clk);
    fire = req_tvalid & req_tready;
    last_fire = 0;
    for (int r = 0; r < NREQ; r++) if (fire[r] && req_tlast[r]) last_fire = 1;
    if (pool_tvalid && pool_tready) blog.push_back({pool_tlast, pool_tdata});
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      if (fire[r]) begin
        if (src_beat[r] == src_len[r] - 1) begin
          src_beat[r] = 0;
          if (!src_rep[r]) src_on[r] = 0;
        end else begin
          src_beat[r]++;
        end
      end
    end
    if (last_fire) begin wcnt = 1; t_entry = cyc; end
    else if (wcnt > 0) wcnt++;
    pool_layer_done = (done_at != 0 && wcnt == done_at);
    if (pool_layer_done) wcnt = 0;
    if (tog) pool_tready = ~pool_tready;
    pool_busy = 1'($urandom);
    if (pool_config_valid) begin glog.push_back(int'(grant_id)); cdlog.push_back(pool_config_data); end
    if (frame_done) n_fdone++;
    if (busy_prev && !sched_busy) t_idle = cyc;
    busy_prev = sched_busy;
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1;
    for (int r = 0; r < NREQ; r++) set_src(r, 0, 0, 1);
    pool_layer_done = 0; pool_tready = 1; tog = 0; enable = 1;
    done_at = 2; wcnt = 0;
    repeat (2) step();
    rst = 0;
    glog.delete(); cdlog.delete(); blog.delete();
    n_fdone = 0; t_entry = -1; t_idle = -1; busy_prev = 0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (n_fdone < target && n < budget) begin step(); n++; end
    if (n_fdone < target) check("wait_frames_budget", n_fdone, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (t_idle < 0 && n < budget) begin step(); n++; end
    if (t_idle < 0) check("wait_idle_budget", 0, 1);
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    for (int r = 0; r < NREQ; r++) req_cfg[32*r +: 32] = cfg_of(r);

    // Reset values
    do_reset();
    check("reset_busy", sched_busy, 0);
    check("reset_grant", grant_id, 0);
    check("reset_count", frame_count, 0);
    check("reset_terr", timeout_err, 0);

    // Two of four valid: lowest at/after pointer 0 wins, then pointer moves past it
    set_src(1, 1, 0, 1);
    set_src(2, 1, 0, 1);
    wait_frames(2, 100);
    check("t1_ngrants", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("t1_grant0", glog[0], 1);
      check("t1_grant1", glog[1], 2);
      check("t1_cfg0", cdlog[0], 32'hC0F1_0001);
    end
    if (blog.size() >= 2) begin
      check("t1_beat0", blog[0], {1'b1, 32'hD000_0100});
      check("t1_beat1", blog[1], {1'b1, 32'hD000_0200});
    end

    // Toggling pool_tready across a 5-beat frame
    do_reset();
    tog = 1;
    set_src(2, 1, 0, 5);
    wait_frames(1, 200);
    check("t2_nbeats", blog.size(), 5);
    for (int i = 0; i < 5 && i < blog.size(); i++)
      check("t2_beat", blog[i], {(i == 4) ? 1'b1 : 1'b0, 32'hD000_0200 + 32'(i)});
    check("t2_count", frame_count, 1);

    // All four valid continuously: fair rotation, then counter wrap
    do_reset();
    for (int r = 0; r < NREQ; r++) set_src(r, 1, 1, 2);
    wait_frames(8, 400);
    check("t3_count8", frame_count, 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) check("t3_order", glog[i], exp_order[i]);
    wait_frames(16, 400);
    check("t3_wrap", frame_count, 0);

    // Done withheld: timeout after 16 WAIT cycles, pointer still advances
    do_reset();
    done_at = 0;
    set_src(1, 1, 0, 2);
    wait_idle(100);
    check("t4_wait_len", t_idle - t_entry, 16);
    check("t4_terr", timeout_err, 1);
    check("t4_nodone", n_fdone, 0);
    check("t4_count", frame_count, 0);
    done_at = 2;
    set_src(0, 1, 0, 1);
    set_src(2, 1, 0, 1);
    wait_frames(1, 100);
    check("t4_next_grant", glog.size() >= 2 ? glog[1] : -1, 2);
    check("t4_terr_sticky", timeout_err, 1);

    // Done coincident with timeout: done wins
    do_reset();
    done_at = 16;
    set_src(0, 1, 0, 1);
    wait_frames(1, 100);
    check("t5_wait_len", t_idle - t_entry, 16);
    check("t5_terr", timeout_err, 0);
    check("t5_count", frame_count, 1);

    // Stray done in IDLE; enable gates grants but not a frame already granted
    do_reset();
    pool_layer_done = 1;
    step();
    step();
    check("t6_stray_done", n_fdone, 0);
    enable = 0;
    set_src(1, 1, 0, 3);
    repeat (6) step();
    check("t6_blocked", sched_busy, 0);
    check("t6_no_grant", glog.size(), 0);
    enable = 1;
    for (int n = 0; n < 20 && glog.size() == 0; n++) step();
    enable = 0;
    wait_frames(1, 100);
    check("t6_completed", frame_count, 1);
    set_src(2, 1, 0, 1);
    repeat (5) step();
    check("t6_still_blocked", glog.size(), 1);

    // Reset while beat 3 of a frame is presented
    do_reset();
    set_src(2, 1, 0, 1);
    wait_frames(1, 100);
    set_src(3, 1, 0, 5);
    for (int n = 0; n < 50 && blog.size() < 3; n++) step();
    check("t7_pre_beats", blog.size(), 3);
    check("t7_pre_valid", pool_tvalid, 1);
    #2;
    rst = 1;
    #1;
    check("t7_rst_tvalid", pool_tvalid, 0);
    check("t7_rst_tlast", pool_tlast, 0);
    check("t7_rst_tready", req_tready, 0);
    check("t7_rst_busy", sched_busy, 0);
    do_reset();
    check("t7_idle", sched_busy, 0);
    for (int r = 0; r < NREQ; r++) set_src(r, 1, 1, 1);
    wait_frames(1, 100);
    check("t7_first_grant", glog.size() > 0 ? glog[0] : -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
